mac_d_fifo: RTL
===============

# mac_d_fifo

Elastic first-word-fall-through buffer on the MAC result stream. It sits between the `d` stream source of the MAC engine and the `d` stream sink of the MAC streamer. It absorbs back-pressure from the TCDM store path, so the engine does not stall on single-cycle memory contention. It also reports occupancy and a high-water mark, which the controller uses for debug and sizing.

## Interface
- `DATA_WIDTH`, 32, width of the stream payload.
- `DEPTH`, 4, number of entries; must be a power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH+1)`, derived width of the count outputs; not to be overridden.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `clear_i`  in  1  synchronous flush, same effect as `rst_i`; driven from the controller `clear`.
- `push_data_i`  in  `DATA_WIDTH`  payload from the engine.
- `push_strb_i`  in  `DATA_WIDTH/8`  byte strobe from the engine; stored with the data.
- `push_valid_i`  in  1  engine has a word.
- `push_ready_o`  out  1  FIFO accepts a word this cycle.
- `pop_data_o`  out  `DATA_WIDTH`  head payload toward the streamer.
- `pop_strb_o`  out  `DATA_WIDTH/8`  head strobe.
- `pop_valid_o`  out  1  head word is valid.
- `pop_ready_i`  in  1  streamer takes the head word.
- `count_o`  out  `CNT_W`  current occupancy, 0..DEPTH.
- `hwm_o`  out  `CNT_W`  maximum occupancy since the last reset or clear.
- `full_o`  out  1  `count_o == DEPTH`.
- `empty_o`  out  1  `count_o == 0`.

## Operation
- Storage is a circular buffer of `DEPTH` entries, each holding {strb, data}.
  - The write pointer and read pointer are `$clog2(DEPTH)` bits wide.
  - Both pointers wrap from `DEPTH-1` to 0 naturally.
  - Full and empty are derived from `count_o`, never from pointer comparison.
- A push occurs in a cycle where `push_valid_i & push_ready_o`:
  - the entry is written at the write pointer;
  - the write pointer increments.
- A pop occurs in a cycle where `pop_valid_o & pop_ready_i`; the read pointer increments.
- Count update on each edge:
  - +1 on push only;
  - −1 on pop only;
  - unchanged when a push and a pop occur together or when neither occurs.
- `push_ready_o = ~full_o & ~rst_i & ~clear_i`.
  - It does not depend on `pop_ready_i`.
  - When full, no same-cycle push is accepted even if a pop occurs.
- `pop_valid_o = ~empty_o & ~rst_i & ~clear_i`.
- There is no bypass: a word pushed into an empty FIFO appears at the head on the next cycle.
- `pop_data_o` and `pop_strb_o` show the entry at the read pointer.
  - They are don't-care while `pop_valid_o = 0`.
  - They must be stable while `pop_valid_o = 1 & pop_ready_i = 0`.
- `hwm_o` is updated to `max(hwm_o, next count)` on every edge.
- Reset and clear behave identically, and both take priority over push and pop in the same cycle:
  - pointers, count and `hwm_o` go to 0;
  - storage contents are left unchanged;
  - any in-flight handshake in that cycle is dropped.
- Violating the stream protocol upstream (for example, payload changing under `push_valid_i` without ready) is not detected; the FIFO stores whatever is present at the push edge.

## Timing
- Reset values, seen after the first edge with `rst_i = 1`:
  - `count_o = 0`, `hwm_o = 0`;
  - `empty_o = 1`, `full_o = 0`, `pop_valid_o = 0`.
- While `rst_i` or `clear_i` is high, `push_ready_o = 0` and `pop_valid_o = 0`.
- The cycle after both are low, `push_ready_o = 1`.
- Push-to-pop latency is 1 cycle: a word pushed at edge N has `pop_valid_o = 1` during cycle N+1.
- Sustained throughput is 1 word/cycle when both sides are always ready.
  - In that steady state, `count_o` stays at 1 after the first fill cycle.
- Full boundary:
  - at `count_o == DEPTH`, `push_ready_o = 0`;
  - a pop at edge N reopens `push_ready_o` in cycle N+1.
- Empty boundary: the last pop at edge N gives `pop_valid_o = 0` and `empty_o = 1` in cycle N+1.
- Combinational paths:
  - `clear_i` and `rst_i` reach `push_ready_o` and `pop_valid_o` only through the gating terms above;
  - there is no path from `pop_ready_i` to `push_ready_o` and none from `push_valid_i` to `pop_valid_o`.
- All other outputs are functions of registered state only.

## Test plan
- **Basic fill/drain:** hold `pop_ready_i = 0` and push 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Expected: `full_o = 1`, `push_ready_o = 0`, `count_o = 4`, `hwm_o = 4`.
  - Then assert `pop_ready_i` for 4 cycles. Expected: outputs 0x11..0x44 in order, then `empty_o = 1`, and `hwm_o` stays at 4.
- **Streaming:** push and pop valid/ready held high for 100 cycles with an incrementing counter payload.
  - Expected: 99 pops in order with no gaps, `count_o = 1` throughout, `hwm_o = 1`.
- **Full with simultaneous pop:** with the FIFO full, drive `push_valid_i = 1` and `pop_ready_i = 1`.
  - Expected: the push is rejected that cycle and the pop occurs, so `count_o = 3`.
  - Next cycle: the push is accepted together with the pop, and `count_o` stays at 3.
- **Wrap-around:** run 3 rounds of push 3 / pop 3 with random strobes and data.
  - Expected: the scoreboard matches data and strobe across pointer wrap.
- **Clear mid-operation:** with `count_o = 2`, assert `clear_i` for 1 cycle together with `push_valid_i` and `pop_ready_i`.
  - Expected: no handshake occurs; the next cycle shows `count_o = 0`, `hwm_o = 0`, `pop_valid_o = 0`, `push_ready_o = 1`.
- **Random back-pressure:** run 10k cycles with random valid and ready, each high with probability 50%.
  - Expected: the data order is preserved and `count_o` matches the reference model every cycle.

Source files
------------

// File: rtl/mac_d_fifo.sv
// Elastic first-word-fall-through buffer on the MAC result stream.
// Each entry holds {strb, data}. Full and empty come from the occupancy count.
// The count_o and hwm_o outputs let the controller observe how deep the buffer runs.
`timescale 1ns/1ps

module mac_d_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic [DATA_WIDTH-1:0]   push_data_i,
   input  logic [DATA_WIDTH/8-1:0] push_strb_i,
   input  logic                    push_valid_i,
   output logic                    push_ready_o,
   output logic [DATA_WIDTH-1:0]   pop_data_o,
   output logic [DATA_WIDTH/8-1:0] pop_strb_o,
   output logic                    pop_valid_o,
   input  logic                    pop_ready_i,
   output logic [CNT_W-1:0]        count_o,
   output logic [CNT_W-1:0]        hwm_o,
   output logic                    full_o,
   output logic                    empty_o
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int ENT_W  = DATA_WIDTH + STRB_W;
   localparam int PTR_W  = $clog2(DEPTH);

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] hwm_q, hwm_d;
   logic             flush;
   logic             push;
   logic             pop;
   logic [ENT_W-1:0] head;

   assign flush = rst_i | clear_i;

   // Status flags and handshake outputs; flush only gates the two handshake terms.
   always_comb begin
      full_o       = (count_q == CNT_W'(DEPTH));
      empty_o      = (count_q == '0);
      push_ready_o = ~full_o & ~flush;
      pop_valid_o  = ~empty_o & ~flush;
      count_o      = count_q;
      hwm_o        = hwm_q;
      head         = mem_q[rd_ptr_q];
      pop_data_o   = head[DATA_WIDTH-1:0];
      pop_strb_o   = head[ENT_W-1:DATA_WIDTH];
   end

   assign push = push_valid_i & push_ready_o;
   assign pop  = pop_valid_o & pop_ready_i;

   // Next-state for the pointers, the count and the high-water mark.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
      hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
   end

   // Storage write: only the entry under the write pointer changes on a push.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = {push_strb_i, push_data_i};
      end
   end

   // Control state register; reset and clear flush it but leave storage alone.
   always_ff @(posedge clk_i) begin
      if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hwm_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hwm_q    <= hwm_d;
      end
   end

   // Storage register, not reset.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule
